m_mem_access: RTL and testbench

//  M-stage consumer of the E->M pipeline register: decodes M_Instr, drives one data-memory bus transaction
//  per load/store (M_C = byte address, M_Rt_data = store data), and returns extended load data to the W-stage register.

---
 rtl/m_mem_access_pkg.sv | 43 ++++
 rtl/m_mem_access_if.sv | 15 +
 rtl/m_load_ext.sv | 39 +++
 rtl/m_mem_access.sv | 142 ++++++++++++++
 tb/tb_m_mem_access.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_mem_access_pkg.sv
// Shared definitions for the M-stage memory access block: opcodes, FSM encodings,
// byte-enable constants and the op decoder.
package m_mem_access_pkg;

  localparam logic [5:0] OPC_LB  = 6'h20;
  localparam logic [5:0] OPC_LH  = 6'h21;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_LBU = 6'h24;
  localparam logic [5:0] OPC_LHU = 6'h25;
  localparam logic [5:0] OPC_SB  = 6'h28;
  localparam logic [5:0] OPC_SH  = 6'h29;
  localparam logic [5:0] OPC_SW  = 6'h2B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [3:0] {
    OP_NONE, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } mem_op_e;

  function automatic mem_op_e decode_op(input logic [5:0] opc);
    mem_op_e op;
    case (opc)
      OPC_LW:  op = OP_LW;
      OPC_LH:  op = OP_LH;
      OPC_LHU: op = OP_LHU;
      OPC_LB:  op = OP_LB;
      OPC_LBU: op = OP_LBU;
      OPC_SW:  op = OP_SW;
      OPC_SH:  op = OP_SH;
      OPC_SB:  op = OP_SB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/m_mem_access_if.sv
// Data-memory bus between the M stage (master) and the memory system (slave).
interface m_mem_access_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_byteen;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  modport master (output m_req, m_we, m_addr, m_byteen, m_wdata,
                  input  m_ready, m_rdata);
  modport slave  (input  m_req, m_we, m_addr, m_byteen, m_wdata,
                  output m_ready, m_rdata);
endinterface

// File: rtl/m_load_ext.sv
// Selects the addressed byte/half of a captured bus word and sign- or zero-extends it.
module m_load_ext
  import m_mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  mem_op_e     i_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  // Stores and bubbles return zero so W never sees stale bus data.
  always_comb begin
    o_data = 32'h0;
    case (i_op)
      OP_LW:   o_data = i_word;
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0, w_half};
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h0, w_byte};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/m_mem_access.sv
// M-stage memory access: decodes the instruction in M, runs one bus transaction per
// load/store with a bounded wait, and stalls the pipeline until the result is ready.
module m_mem_access
  import m_mem_access_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       i_M_Instr,
  input  logic [31:0]       i_M_C,
  input  logic [31:0]       i_M_Rt_data,
  input  logic              i_adv,
  m_mem_access_if.master    bus,
  output logic              o_M_stall,
  output logic [31:0]       o_M_mem_data,
  output logic              o_addr_err,
  output logic              o_bus_err
);

  mem_op_e     w_op;
  logic        w_mem_op;
  logic        w_is_word;
  logic        w_is_half;
  logic        w_is_store;
  logic        w_start;
  logic [3:0]  w_byteen;
  logic [31:0] w_wdata;
  logic        w_unused;

  logic [1:0]        r_state;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_byteen;
  logic [31:0]       r_wdata;
  mem_op_e           r_op;
  logic [1:0]        r_lane;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [31:0]       r_rdata;
  logic              r_bus_err;

  // Only the major opcode selects a memory op; register/immediate fields are irrelevant here.
  assign w_unused   = ^i_M_Instr[25:0];
  assign w_op       = decode_op(i_M_Instr[31:26]);
  assign w_mem_op   = (w_op != OP_NONE);
  assign w_is_word  = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_is_half  = (w_op == OP_LH) || (w_op == OP_LHU) || (w_op == OP_SH);
  assign w_is_store = (w_op == OP_SW) || (w_op == OP_SH) || (w_op == OP_SB);

  assign o_addr_err = w_mem_op & ((w_is_word & (i_M_C[1:0] != 2'b00)) | (w_is_half & i_M_C[0]));
  assign w_start    = (r_state == ST_IDLE) & w_mem_op & ~o_addr_err;
  assign o_M_stall  = w_start | (r_state == ST_BUSY);

  always_comb begin
    w_byteen = 4'b0000;
    w_wdata  = 32'h0;
    case (w_op)
      OP_LW, OP_SW:          w_byteen = BE_WORD;
      OP_LH, OP_LHU, OP_SH:  w_byteen = i_M_C[1] ? BE_HALF_HI : BE_HALF_LO;
      OP_LB, OP_LBU, OP_SB:  w_byteen = BE_BYTE0 << i_M_C[1:0];
      default:               w_byteen = 4'b0000;
    endcase
    case (w_op)
      OP_SW:   w_wdata = i_M_Rt_data;
      OP_SH:   w_wdata = {2{i_M_Rt_data[15:0]}};
      OP_SB:   w_wdata = {4{i_M_Rt_data[7:0]}};
      default: w_wdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_byteen   <= 4'b0000;
      r_wdata    <= 32'h0;
      r_op       <= OP_NONE;
      r_lane     <= 2'b00;
      r_wait_cnt <= '0;
      r_rdata    <= 32'h0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_BUSY;
            r_req      <= 1'b1;
            r_we       <= w_is_store;
            r_addr     <= {i_M_C[31:2], 2'b00};
            r_byteen   <= w_byteen;
            r_wdata    <= w_wdata;
            r_op       <= w_op;
            r_lane     <= i_M_C[1:0];
            r_wait_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (bus.m_ready) begin
            r_req   <= 1'b0;
            r_rdata <= r_we ? 32'h0 : bus.m_rdata;
            r_state <= ST_DONE;
          end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
            // Abort: the slave never answered, hand W a zero result flagged by bus_err.
            r_req     <= 1'b0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_adv) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_req    = r_req;
  assign bus.m_we     = r_we;
  assign bus.m_addr   = r_addr;
  assign bus.m_byteen = r_byteen;
  assign bus.m_wdata  = r_wdata;
  assign o_bus_err    = r_bus_err;

  m_load_ext u_load_ext (
    .i_word (r_rdata),
    .i_lane (r_lane),
    .i_op   (r_op),
    .o_data (o_M_mem_data)
  );

endmodule

// File: tb/tb_m_mem_access.sv
// Scoreboard bench for m_mem_access: expected bus/result records are queued per access
// and compared against what the bus monitor observed.
module tb_m_mem_access;
  import m_mem_access_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        berr;
    logic [7:0]  stalls;
    logic [7:0]  reqs;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_instr = 32'h0;
  logic [31:0] i_c = 32'h0;
  logic [31:0] i_rt = 32'h0;
  logic        i_adv = 1'b0;
  logic        o_stall;
  logic [31:0] o_mem;
  logic        o_aerr;
  logic        o_berr;

  int   n_vec = 0;
  int   n_err = 0;
  acc_t obs;
  acc_t exp_v;
  acc_t sb_q[$];

  m_mem_access_if bus();

  m_mem_access #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .i_M_Instr    (i_instr),
    .i_M_C        (i_c),
    .i_M_Rt_data  (i_rt),
    .i_adv        (i_adv),
    .bus          (bus),
    .o_M_stall    (o_stall),
    .o_M_mem_data (o_mem),
    .o_addr_err   (o_aerr),
    .o_bus_err    (o_berr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [5:0] opc);
    return {opc, 26'h0123456};
  endfunction

  function automatic acc_t mk_exp(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic [31:0] data,
                                  input logic berr, input int stalls, input int reqs);
    acc_t e;
    e = {we, addr, be, wdata, data, berr, 8'(stalls), 8'(reqs)};
    return e;
  endfunction

  // Drives one instruction, plays the slave (ready on the ready_at-th request cycle, 0 = never)
  // and records what the DUT put on the bus plus its result.
  task automatic do_access(input logic [31:0] instr, input logic [31:0] c, input logic [31:0] rt,
                           input logic [31:0] rd, input int ready_at, input bit do_adv);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    obs = '0;
    i_instr = instr; i_c = c; i_rt = rt;
    bus.m_ready = 1'b0; bus.m_rdata = rd;
    #1;
    for (int k = 0; k < 40; k++) begin
      if (!o_stall) begin done = 1; break; end
      stalls++;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      if (bus.m_req) begin
        reqs++;
        if (reqs == 1) begin
          obs.we = bus.m_we; obs.addr = bus.m_addr; obs.be = bus.m_byteen; obs.wdata = bus.m_wdata;
        end
        if (reqs == ready_at) bus.m_ready = 1'b1;
      end
      #1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL access_bound: stall still %b after 40 cycles, required 0", o_stall);
    end
    obs.data = o_mem; obs.berr = o_berr; obs.stalls = 8'(stalls); obs.reqs = 8'(reqs);
    i_instr = 32'h0;
    if (do_adv) begin
      i_adv = 1'b1; @(posedge clk); #1; i_adv = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b0; bus.m_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_byteen, bus.m_wdata, o_mem, o_berr, o_stall, o_aerr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wdata=%h data=%h berr=%b stall=%b aerr=%b, required all 0",
               bus.m_req, bus.m_we, bus.m_addr, bus.m_byteen, bus.m_wdata, o_mem, o_berr, o_stall, o_aerr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL reset_release_req: got %b required 0", bus.m_req); end
    $display("reset: done");
  endtask

  task automatic test_store();
    sb_q.push_back(mk_exp(1'b1, 32'h0000_1008, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 4, 3));
    do_access(mk(OPC_SW), 32'h0000_1008, 32'hDEADBEEF, 32'h0, 3, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL store_sw: got %h required %h", obs, exp_v); end
    $display("sw  addr=%h be=%b wdata=%h stalls=%0d", obs.addr, obs.be, obs.wdata, obs.stalls);

    sb_q.push_back(mk_exp(1'b1, 32'h0000_1000, 4'b0010, 32'h78787878, 32'h0, 1'b0, 3, 2));
    do_access(mk(OPC_SB), 32'h0000_1001, 32'h12345678, 32'h0, 2, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL store_sb: got %h required %h", obs, exp_v); end
    $display("sb  addr=%h be=%b wdata=%h stalls=%0d", obs.addr, obs.be, obs.wdata, obs.stalls);
  endtask

  task automatic test_load_byte();
    sb_q.push_back(mk_exp(1'b0, 32'h0000_2000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 2));
    do_access(mk(OPC_LB), 32'h0000_2003, 32'h0, 32'h80FF_1234, 2, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_lb: got %h required %h", obs, exp_v); end
    $display("lb  addr=%h be=%b data=%h", obs.addr, obs.be, obs.data);

    sb_q.push_back(mk_exp(1'b0, 32'h0000_2000, 4'b1000, 32'h0, 32'h0000_0080, 1'b0, 2, 1));
    do_access(mk(OPC_LBU), 32'h0000_2003, 32'h0, 32'h80FF_1234, 1, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_lbu: got %h required %h", obs, exp_v); end
    $display("lbu addr=%h be=%b data=%h", obs.addr, obs.be, obs.data);

    sb_q.push_back(mk_exp(1'b0, 32'h0000_0000, 4'b0010, 32'h0, 32'h0000_007F, 1'b0, 2, 1));
    do_access(mk(OPC_LB), 32'h0000_0001, 32'h0, 32'h0000_7F00, 1, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_lb_pos: got %h required %h", obs, exp_v); end
    $display("lb  addr=%h be=%b data=%h", obs.addr, obs.be, obs.data);

    sb_q.push_back(mk_exp(1'b0, 32'h0000_0004, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1));
    do_access(mk(OPC_LW), 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 1, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_lw: got %h required %h", obs, exp_v); end
    $display("lw  addr=%h be=%b data=%h", obs.addr, obs.be, obs.data);
  endtask

  task automatic test_half();
    sb_q.push_back(mk_exp(1'b1, 32'h0000_0000, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 2, 1));
    do_access(mk(OPC_SH), 32'h0000_0002, 32'h0000_ABCD, 32'h0, 1, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL store_sh: got %h required %h", obs, exp_v); end
    $display("sh  addr=%h be=%b wdata=%h", obs.addr, obs.be, obs.wdata);

    sb_q.push_back(mk_exp(1'b0, 32'h0000_0000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 2, 1));
    do_access(mk(OPC_LH), 32'h0000_0002, 32'h0, 32'h8001_0000, 1, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_lh: got %h required %h", obs, exp_v); end
    $display("lh  addr=%h be=%b data=%h", obs.addr, obs.be, obs.data);

    sb_q.push_back(mk_exp(1'b0, 32'h0000_0004, 4'b1100, 32'h0, 32'h0000_9ABC, 1'b0, 2, 1));
    do_access(mk(OPC_LHU), 32'h0000_0006, 32'h0, 32'h9ABC_5555, 1, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL load_lhu: got %h required %h", obs, exp_v); end
    $display("lhu addr=%h be=%b data=%h", obs.addr, obs.be, obs.data);
  endtask

  task automatic test_misaligned();
    int reqs = 0;
    int stalls = 0;
    logic aerr;
    i_instr = mk(OPC_LW); i_c = 32'h0000_0001; #1;
    aerr = o_aerr;
    for (int k = 0; k < 3; k++) begin
      if (o_stall) stalls++;
      @(posedge clk); #1;
      if (bus.m_req) reqs++;
    end
    n_vec++;
    if (aerr !== 1'b1) begin n_err++; $display("FAIL misaligned_lw_aerr: got %b required 1", aerr); end
    n_vec++;
    if (reqs != 0 || stalls != 0) begin
      n_err++; $display("FAIL misaligned_lw_quiet: got reqs=%0d stalls=%0d required 0/0", reqs, stalls);
    end
    $display("lw  misaligned aerr=%b reqs=%0d stalls=%0d", aerr, reqs, stalls);

    i_instr = mk(OPC_LH); i_c = 32'h0000_0003; #1;
    n_vec++;
    if (o_aerr !== 1'b1) begin n_err++; $display("FAIL misaligned_lh_aerr: got %b required 1", o_aerr); end
    i_c = 32'h0000_0002; #1;
    n_vec++;
    if ({o_aerr, o_stall} !== 2'b01) begin
      n_err++; $display("FAIL aligned_lh_aerr: got aerr=%b stall=%b required 0/1", o_aerr, o_stall);
    end
    i_instr = 32'h0; #1;
    $display("lh  alignment checks done");
  endtask

  task automatic test_timeout();
    sb_q.push_back(mk_exp(1'b0, 32'h0000_0040, 4'b1111, 32'h0, 32'h0, 1'b1, 6, 5));
    do_access(mk(OPC_LW), 32'h0000_0040, 32'h0, 32'h5A5A_5A5A, 0, 1);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timeout_abort: got %h required %h", obs, exp_v); end
    n_vec++;
    if (o_berr !== 1'b0) begin n_err++; $display("FAIL timeout_berr_clear: got %b required 0", o_berr); end
    $display("lw  timeout reqs=%0d berr=%b data=%h", obs.reqs, obs.berr, obs.data);
  endtask

  task automatic test_reset_mid();
    int reqs = 0;
    i_instr = mk(OPC_LW); i_c = 32'h0000_0100; bus.m_ready = 1'b0; #1;
    @(posedge clk); #1;
    i_instr = 32'h0;
    n_vec++;
    if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL midreset_busy: got req=%b required 1", bus.m_req); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.m_req, o_stall, o_berr} !== 3'b000) begin
      n_err++; $display("FAIL midreset_drop: got req=%b stall=%b berr=%b required 0/0/0", bus.m_req, o_stall, o_berr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.m_req) reqs++;
    end
    n_vec++;
    if (reqs != 0) begin n_err++; $display("FAIL midreset_after: got reqs=%0d required 0", reqs); end
    $display("reset mid-transaction: req dropped");
  endtask

  task automatic test_no_reissue();
    int reqs = 0;
    int stalls = 0;
    sb_q.push_back(mk_exp(1'b0, 32'h0000_0200, 4'b1111, 32'h0, 32'h1357_9BDF, 1'b0, 2, 1));
    do_access(mk(OPC_LW), 32'h0000_0200, 32'h0, 32'h1357_9BDF, 1, 0);
    exp_v = sb_q.pop_front();
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL hold_access: got %h required %h", obs, exp_v); end
    // Hold DONE with the same instruction present, as a frozen pipeline would.
    i_instr = mk(OPC_LW); i_c = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.m_req) reqs++;
      if (o_stall) stalls++;
    end
    n_vec++;
    if (reqs != 0 || stalls != 0) begin
      n_err++; $display("FAIL hold_no_reissue: got reqs=%0d stalls=%0d required 0/0", reqs, stalls);
    end
    n_vec++;
    if (o_mem !== 32'h1357_9BDF) begin n_err++; $display("FAIL hold_data: got %h required 13579bdf", o_mem); end
    i_instr = 32'h0; i_adv = 1'b1;
    @(posedge clk); #1;
    i_adv = 1'b0;
    $display("lw  held in DONE reqs=%0d data=%h", reqs, o_mem);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_byte();
    test_half();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_no_reissue();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
